amo_queue: RTL

AMO_QUEUE -- requirements
Module: amo_queue

---
 rtl/amo_queue.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/amo_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | amo_queue: in-order AMO queue; entries issue to the cache once committed |
// | and the store buffer is drained. Option: AMO_QUEUE_CAP_TAG_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package config_pkg;
  typedef struct packed {
    int unsigned PLEN;
    int unsigned CLEN;
    int unsigned CheriCapTagWidth;
    int unsigned DCACHE_DATA_SIZE_WIDTH;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    PLEN: 32'd34,
    CLEN: 32'd64,
    CheriCapTagWidth: 32'd1,
    DCACHE_DATA_SIZE_WIDTH: 32'd2
  };
endpackage

package ariane_pkg;
  typedef enum logic [3:0] {
    AMO_NONE = 4'd0, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
    AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
  } amo_t;

  typedef struct packed {
    logic        req;
    amo_t        amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;
endpackage

module amo_queue #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           DEPTH   = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  input  ariane_pkg::amo_t                          amo_op_i,
  input  logic [CVA6Cfg.PLEN-1:0]                   paddr_i,
  input  logic [CVA6Cfg.CLEN-1:0]                   data_i,
  input  logic [CVA6Cfg.CheriCapTagWidth-1:0]       cap_tag_i,
  input  logic [CVA6Cfg.DCACHE_DATA_SIZE_WIDTH-1:0] data_size_i,
  input  logic                                      commit_i,
  input  logic                                      no_st_pending_i,
  output ariane_pkg::amo_req_t                      amo_req_o,
  input  ariane_pkg::amo_resp_t                     amo_resp_i,
  output logic [CVA6Cfg.CheriCapTagWidth-1:0]       amo_tag_o,
  output logic [$clog2(DEPTH):0]                    usage_o,
  output logic                                      empty_o
);

  localparam int unsigned C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned C_CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_PTR_W-1:0]   r_head;
  logic [C_PTR_W-1:0]   r_commit;
  logic [C_PTR_W-1:0]   r_tail;
  logic [C_CNT_W-1:0]   r_usage;
  logic [C_CNT_W-1:0]   r_committed;
  logic [C_PTR_W-1:0]   w_commit_ptr_nxt;
  logic [C_CNT_W-1:0]   w_committed_nxt;
  logic                 w_push;
  logic                 w_commit;
  logic                 w_pop;
  logic                 w_unused;

  ariane_pkg::amo_t                          r_op   [DEPTH];
  logic [CVA6Cfg.PLEN-1:0]                   r_addr [DEPTH];
  logic [CVA6Cfg.CLEN-1:0]                   r_data [DEPTH];
  logic [CVA6Cfg.DCACHE_DATA_SIZE_WIDTH-1:0] r_size [DEPTH];

  function automatic logic [C_PTR_W-1:0] f_inc(input logic [C_PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign ready_o  = (r_usage != C_CNT_W'(DEPTH)) && !flush_i;
  assign w_push   = valid_i && ready_o;
  // Only entries already stored and not yet committed can be committed.
  assign w_commit = commit_i && (r_usage != r_committed);
  assign w_pop    = (r_state == ISSUE) && amo_resp_i.ack;

  assign w_commit_ptr_nxt = w_commit ? f_inc(r_commit) : r_commit;
  assign w_committed_nxt  = r_committed + C_CNT_W'(w_commit) - C_CNT_W'(w_pop);

  assign usage_o = r_usage;
  assign empty_o = (r_usage == '0);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_op[r_tail]   <= amo_op_i;
      r_addr[r_tail] <= paddr_i;
      r_data[r_tail] <= data_i;
      r_size[r_tail] <= data_size_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_commit    <= '0;
      r_tail      <= '0;
      r_usage     <= '0;
      r_committed <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_head      <= w_pop ? f_inc(r_head) : r_head;
      r_commit    <= w_commit_ptr_nxt;
      r_committed <= w_committed_nxt;
      // Flush keeps only committed entries (including one in flight).
      if (flush_i) begin
        r_tail  <= w_commit_ptr_nxt;
        r_usage <= w_committed_nxt;
      end else begin
        r_tail  <= w_push ? f_inc(r_tail) : r_tail;
        r_usage <= r_usage + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if ((r_committed != '0) && no_st_pending_i) w_state_nxt = ISSUE;
      ISSUE:   if (amo_resp_i.ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    amo_req_o = '0;
    if (r_state == ISSUE) begin
      amo_req_o.req       = 1'b1;
      amo_req_o.amo_op    = r_op[r_head];
      amo_req_o.size      = r_size[r_head];
      amo_req_o.operand_a = 64'(r_addr[r_head]);
      amo_req_o.operand_b = 64'(r_data[r_head]);
    end
  end

`ifdef AMO_QUEUE_CAP_TAG_EN
  logic [CVA6Cfg.CheriCapTagWidth-1:0] r_tag [DEPTH];

  always_ff @(posedge clk_i) begin
    if (w_push) r_tag[r_tail] <= cap_tag_i;
  end

  assign amo_tag_o = (r_state == ISSUE) ? r_tag[r_head] : '0;
  assign w_unused  = ^amo_resp_i.result;
`else
  assign amo_tag_o = '0;
  assign w_unused  = ^{amo_resp_i.result, cap_tag_i};
`endif

endmodule
`default_nettype wire
